// File: rtl/seq_game_ctrl.sv
// Memory-game sequencer: grows a nibble sequence by one step per round, plays it back
// with fixed show/gap timing, then checks the player's entries step by step.
module seq_game_ctrl #(
  parameter int DEPTH    = 8,
  parameter int SHOW_CYC = 4,
  parameter int GAP_CYC  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [3:0]                 rnd,
  input  logic                       btn_valid,
  input  logic [3:0]                 btn_val,
  output logic                       show_valid,
  output logic [3:0]                 show_val,
  output logic                       await_input,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       win,
  output logic                       fail
);

  localparam int LEN_W   = $clog2(DEPTH + 1);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int TMR_MAX = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] SHOW_LAST = TMR_W'(SHOW_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYC - 1);
  localparam logic [LEN_W-1:0] LEN_FULL  = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_PLAY_ON,
    S_PLAY_OFF,
    S_WAIT_IN,
    S_WIN,
    S_FAIL
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_next;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] idx_next;
  logic [LEN_W-1:0] last_idx;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_next;
  logic             mem_we;
  logic             idx_at_last;
  logic [3:0]       cur_val;
  logic [3:0]       mem [DEPTH];

  // idx never exceeds len-1 and len never exceeds DEPTH, so the narrow slices are safe
  assign last_idx    = len - LEN_ONE;
  assign idx_at_last = (idx == last_idx);
  assign cur_val     = mem[idx[IDX_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    len_next   = len;
    idx_next   = idx;
    timer_next = timer;
    mem_we     = 1'b0;
    case (state)
      S_IDLE, S_WIN, S_FAIL: begin
        if (start) begin
          state_next = S_ADD;
          len_next   = '0;
        end
      end
      S_ADD: begin
        mem_we     = 1'b1;
        len_next   = len + LEN_ONE;
        idx_next   = '0;
        timer_next = '0;
        state_next = S_PLAY_ON;
      end
      S_PLAY_ON: begin
        if (timer == SHOW_LAST) begin
          timer_next = '0;
          state_next = S_PLAY_OFF;
        end else begin
          timer_next = timer + TMR_W'(1);
        end
      end
      S_PLAY_OFF: begin
        if (timer == GAP_LAST) begin
          timer_next = '0;
          if (idx_at_last) begin
            idx_next   = '0;
            state_next = S_WAIT_IN;
          end else begin
            idx_next   = idx + LEN_ONE;
            state_next = S_PLAY_ON;
          end
        end else begin
          timer_next = timer + TMR_W'(1);
        end
      end
      S_WAIT_IN: begin
        // A button press wins over a simultaneous start, which is simply not looked at here
        if (btn_valid) begin
          if (btn_val != cur_val) begin
            state_next = S_FAIL;
          end else if (!idx_at_last) begin
            idx_next = idx + LEN_ONE;
          end else if (len == LEN_FULL) begin
            state_next = S_WIN;
          end else begin
            state_next = S_ADD;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len   <= '0;
      idx   <= '0;
      timer <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      len   <= len_next;
      idx   <= idx_next;
      timer <= timer_next;
      if (mem_we) begin
        mem[len[IDX_W-1:0]] <= rnd;
      end
    end
  end

  assign show_valid  = (state == S_PLAY_ON);
  assign show_val    = show_valid ? cur_val : 4'h0;
  assign await_input = (state == S_WAIT_IN);
  assign level       = len;
  assign win         = (state == S_WIN);
  assign fail        = (state == S_FAIL);

endmodule

// File: tb/tb_seq_game_ctrl.sv
// Bench for seq_game_ctrl: directed game scenarios plus random games, checked against a
// queue-based model of the sequence and the player's position in it.
module tb_seq_game_ctrl;

  localparam int DEPTH    = 4;
  localparam int SHOW_CYC = 2;
  localparam int GAP_CYC  = 1;
  localparam int LEN_W    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [3:0]       rnd;
  logic             btn_valid;
  logic [3:0]       btn_val;
  logic             show_valid;
  logic [3:0]       show_val;
  logic             await_input;
  logic [LEN_W-1:0] level;
  logic             win;
  logic             fail;

  int checks = 0;
  int errors = 0;

  // model: the sequence shown so far and the player's position within it
  int seq[$];
  int pos;

  seq_game_ctrl #(
    .DEPTH   (DEPTH),
    .SHOW_CYC(SHOW_CYC),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rnd        (rnd),
    .btn_valid  (btn_valid),
    .btn_val    (btn_val),
    .show_valid (show_valid),
    .show_val   (show_val),
    .await_input(await_input),
    .level      (level),
    .win        (win),
    .fail       (fail)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] pack(input logic sv, input logic [3:0] sval, input logic aw,
                                       input logic [LEN_W-1:0] lvl, input logic w, input logic f);
    return {sv, sval, aw, lvl, w, f};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected output word: {show_valid, show_val, await_input, level, win, fail}
  task automatic expect_outs(input string tag, input logic sv, input int sval, input logic aw,
                             input int lvl, input logic w, input logic f);
    logic [10:0] obs;
    logic [10:0] exp;
    obs = pack(show_valid, show_val, await_input, level, win, fail);
    exp = pack(sv, 4'(sval), aw, LEN_W'(lvl), w, f);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
    end
  endtask

  // Called while the DUT sits in its one-cycle add state; appends v and checks the playback.
  task automatic add_and_play(input logic [3:0] v, input bit noise);
    expect_outs("add", 1'b0, 0, 1'b0, seq.size(), 1'b0, 1'b0);
    rnd = v;
    seq.push_back(int'(v));
    pos = 0;
    tick();
    rnd = 4'($urandom);
    foreach (seq[i]) begin
      for (int c = 0; c < SHOW_CYC; c++) begin
        expect_outs("show", 1'b1, seq[i], 1'b0, seq.size(), 1'b0, 1'b0);
        if (noise) begin
          btn_valid = 1'($urandom);
          btn_val   = 4'($urandom);
        end
        tick();
      end
      for (int c = 0; c < GAP_CYC; c++) begin
        expect_outs("gap", 1'b0, 0, 1'b0, seq.size(), 1'b0, 1'b0);
        if (noise) begin
          btn_valid = 1'($urandom);
          btn_val   = 4'($urandom);
        end
        tick();
      end
    end
    btn_valid = 1'b0;
    expect_outs("await", 1'b0, 0, 1'b1, seq.size(), 1'b0, 1'b0);
  endtask

  task automatic start_game(input logic [3:0] v, input bit noise);
    start = 1'b1;
    tick();
    start = 1'b0;
    seq.delete();
    add_and_play(v, noise);
  endtask

  // outcome: 0 = keep entering, 1 = next round (now in add), 2 = win, 3 = fail
  task automatic press(input logic [3:0] v, output int outcome);
    btn_valid = 1'b1;
    btn_val   = v;
    tick();
    btn_valid = 1'b0;
    btn_val   = 4'($urandom);
    if (int'(v) != seq[pos]) begin
      outcome = 3;
      expect_outs("press_fail", 1'b0, 0, 1'b0, seq.size(), 1'b0, 1'b1);
    end else if (pos < seq.size() - 1) begin
      pos++;
      outcome = 0;
      expect_outs("press_next", 1'b0, 0, 1'b1, seq.size(), 1'b0, 1'b0);
    end else if (seq.size() == DEPTH) begin
      outcome = 2;
      expect_outs("press_win", 1'b0, 0, 1'b0, seq.size(), 1'b1, 1'b0);
    end else begin
      outcome = 1;
    end
  endtask

  initial begin
    int outcome;
    logic [3:0] v;
    bit done;

    rst_n     = 1'b0;
    start     = 1'b0;
    rnd       = 4'h0;
    btn_valid = 1'b0;
    btn_val   = 4'h0;
    pos       = 0;
    repeat (2) tick();
    expect_outs("reset", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    btn_valid = 1'b1;
    btn_val   = 4'h3;
    tick();
    btn_valid = 1'b0;
    expect_outs("idle_btn", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);

    // first round with value 5, then a second round adding A
    rnd = 4'h5;
    start_game(4'h5, 1'b0);
    press(4'h5, outcome);
    add_and_play(4'hA, 1'b0);

    // 5 then a wrong 3 fails the game; the failure holds until start
    press(4'h5, outcome);
    press(4'h3, outcome);
    for (int i = 0; i < 3; i++) begin
      btn_valid = 1'($urandom);
      btn_val   = 4'($urandom);
      tick();
      expect_outs("fail_hold", 1'b0, 0, 1'b0, 2, 1'b0, 1'b1);
    end
    btn_valid = 1'b0;
    start_game(4'($urandom), 1'b0);
    press(4'(seq[0]) ^ 4'h1, outcome);

    // full game 1,2,3,4 with button noise during playback and start pulses while waiting
    start_game(4'h1, 1'b1);
    for (int r = 2; r <= DEPTH; r++) begin
      for (int k = 0; k < seq.size(); k++) begin
        if (k == 1) begin
          start = 1'b1;
          tick();
          start = 1'b0;
          expect_outs("start_ignored", 1'b0, 0, 1'b1, seq.size(), 1'b0, 1'b0);
        end
        start = (k == 0 && r == 3);
        press(4'(seq[k]), outcome);
        start = 1'b0;
      end
      add_and_play(4'(r), 1'b1);
    end
    for (int k = 0; k < DEPTH; k++) begin
      press(4'(seq[k]), outcome);
    end
    for (int i = 0; i < 3; i++) begin
      btn_valid = 1'b1;
      btn_val   = 4'($urandom);
      tick();
      expect_outs("win_hold", 1'b0, 0, 1'b0, DEPTH, 1'b1, 1'b0);
    end
    btn_valid = 1'b0;

    // a sub-cycle reset pulse in the middle of playback drops everything at once
    start = 1'b1;
    tick();
    start = 1'b0;
    rnd = 4'h7;
    tick();
    expect_outs("pre_reset_show", 1'b1, 7, 1'b0, 1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    expect_outs("async_reset", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    seq.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_outs("post_reset_idle", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    end

    // random games with occasional wrong entries and idle gaps while waiting
    for (int g = 0; g < 8; g++) begin
      start_game(4'($urandom), 1'($urandom));
      done = 1'b0;
      while (!done) begin
        for (int k = 0; k < seq.size(); k++) begin
          repeat ($urandom_range(0, 3)) begin
            tick();
            expect_outs("wait_idle", 1'b0, 0, 1'b1, seq.size(), 1'b0, 1'b0);
          end
          v = 4'(seq[k]);
          if ($urandom_range(0, 9) == 0) v = v ^ 4'($urandom_range(1, 15));
          press(v, outcome);
          if (outcome != 0) break;
        end
        if (outcome == 1) add_and_play(4'($urandom), 1'($urandom));
        else done = 1'b1;
      end
      tick();
      expect_outs("game_end_hold", 1'b0, 0, 1'b0, seq.size(), outcome == 2, outcome == 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
